// File: rtl/jtag_loader_pkg.sv
// Shared constants and encodings for the JTAG configuration frame loader.
package jtag_loader_pkg;

    localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;
    localparam int          END_BIT   = 31;
    localparam int          DATA_W    = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_CHK,
        ST_DONE
    } state_e;

    // FIFO entries are packed {last, addr, data}; addr width is set by the top.
    function automatic int entry_w(input int addr_w);
        return 1 + addr_w + DATA_W;
    endfunction

endpackage

// File: rtl/loader_fifo.sv
// First-word-fall-through FIFO; a write into a full FIFO succeeds when a read happens the same cycle.
module loader_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr, do_rd;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (PW+1)'(DEPTH));
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    // Empty FIFO presents zeros so the output port has a defined idle value.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/jtag_frame_loader.sv
// Parses the TAP PROGRAM word stream into buffered, addressed frame writes.
// Optional per-frame XOR checksum word: define JTAG_FRAME_LOADER_CHECKSUM_EN.
module jtag_frame_loader
    import jtag_loader_pkg::*;
#(
    parameter int FRAME_WORDS = 20,
    parameter int ADDR_W      = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       in_data,
    input  logic              in_strobe,
    input  logic              in_active,
    output logic [ADDR_W-1:0] frame_addr,
    output logic [31:0]       frame_data,
    output logic              frame_last,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);
    localparam int         EW       = entry_w(ADDR_W);
    localparam logic [7:0] LAST_IDX = 8'(FRAME_WORDS - 1);

    typedef struct packed {
        logic              last;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } entry_t;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wcnt_q, wcnt_d;
    logic              error_q, error_d;
    logic              done_q, done_d;
    logic [15:0]       wl_q, wl_d;
`ifdef JTAG_FRAME_LOADER_CHECKSUM_EN
    logic [31:0]       csum_q, csum_d;
`endif

    logic              push, wr_ok, is_last;
    logic              fifo_full, fifo_empty;
    entry_t            wr_entry, head;
    logic [EW-1:0]     rd_bits;

    assign is_last  = (wcnt_q == LAST_IDX);
    assign wr_entry = '{last: is_last, addr: addr_q, data: in_data};
    // A full FIFO still takes the word when the consumer drains one this cycle.
    assign wr_ok    = ~fifo_full | frame_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wcnt_d  = wcnt_q;
        error_d = error_q;
        done_d  = 1'b0;
        wl_d    = wl_q;
        push    = 1'b0;
`ifdef JTAG_FRAME_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        if (!in_active && state_q != ST_DONE) begin
            state_d = ST_IDLE;
            if (state_q != ST_IDLE) error_d = 1'b1;
        end else if (in_strobe) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_data == SYNC_WORD) state_d = ST_ADDR;
                end
                ST_ADDR: begin
                    if (in_data[END_BIT]) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        addr_d  = in_data[ADDR_W-1:0];
                        wcnt_d  = '0;
                        state_d = ST_DATA;
`ifdef JTAG_FRAME_LOADER_CHECKSUM_EN
                        csum_d  = in_data;
`endif
                    end
                end
                ST_DATA: begin
                    push   = 1'b1;
                    wcnt_d = wcnt_q + 8'd1;
                    if (!wr_ok)                error_d = 1'b1;
                    else if (wl_q != 16'hFFFF) wl_d    = wl_q + 16'd1;
`ifdef JTAG_FRAME_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ in_data;
                    if (is_last) state_d = ST_CHK;
`else
                    if (is_last) state_d = ST_ADDR;
`endif
                end
`ifdef JTAG_FRAME_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (in_data != csum_q) error_d = 1'b1;
                    state_d = ST_ADDR;
                end
`endif
                ST_DONE: begin
                    if (in_data == SYNC_WORD) begin
                        state_d = ST_ADDR;
                        error_d = 1'b0;
                        wl_d    = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wcnt_q  <= '0;
            error_q <= 1'b0;
            done_q  <= 1'b0;
            wl_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wcnt_q  <= wcnt_d;
            error_q <= error_d;
            done_q  <= done_d;
            wl_q    <= wl_d;
        end
    end

`ifdef JTAG_FRAME_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) csum_q <= '0;
        else     csum_q <= csum_d;
    end
`endif

    loader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (wr_entry),
        .rd_en   (frame_ready),
        .rd_data (rd_bits),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head         = entry_t'(rd_bits);
    assign frame_addr   = head.addr;
    assign frame_data   = head.data;
    assign frame_last   = head.last;
    assign frame_valid  = ~fifo_empty;
    assign busy         = (state_q != ST_IDLE && state_q != ST_DONE) | ~fifo_empty;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = wl_q;

endmodule

// File: tb/tb_jtag_frame_loader.sv
// Self-checking bench for jtag_frame_loader (FRAME_WORDS=4, FIFO_DEPTH=4); scoreboard on the frame port.
module tb_jtag_frame_loader;
    localparam int          FW   = 4;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;
    localparam logic [31:0] ENDW = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst, in_strobe, in_active, frame_ready;
    logic [31:0] in_data;
    logic [7:0]  frame_addr;
    logic [31:0] frame_data;
    logic        frame_last, frame_valid, busy, done, error;
    logic [15:0] words_loaded;

    always #5 clk = ~clk;

    jtag_frame_loader #(.FRAME_WORDS(FW), .ADDR_W(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_strobe(in_strobe), .in_active(in_active),
        .frame_addr(frame_addr), .frame_data(frame_data), .frame_last(frame_last),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .busy(busy), .done(done),
        .error(error), .words_loaded(words_loaded)
    );

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
        logic        last;
    } sb_t;

    typedef struct {
        logic [31:0] d;
        logic        stb;
        logic        rdy;
        logic        fwd;
        logic [7:0]  fa;
        logic        fl;
        logic        e_done;
        logic        e_busy;
        logic [15:0] e_wl;
        logic        e_err;
    } vec_t;

    sb_t         sbq[$];
    vec_t        vt[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] bcsum;
    logic [7:0]  cur_addr;
    int          wi;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic stb(input logic [31:0] d);
        in_data   = d;
        in_strobe = 1'b1;
        @(posedge clk); #1;
        in_strobe = 1'b0;
    endtask

    task automatic stb_addr(input logic [7:0] a);
        bcsum    = {24'h0, a};
        cur_addr = a;
        wi       = 0;
        stb({24'h0, a});
    endtask

    task automatic stb_data(input logic [31:0] d, input logic fwd);
        bcsum ^= d;
        if (fwd) sbq.push_back('{cur_addr, d, (wi == FW - 1)});
        wi++;
        stb(d);
    endtask

    task automatic send_chk();
`ifdef JTAG_FRAME_LOADER_CHECKSUM_EN
        stb(bcsum);
`endif
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 64 && sbq.size() != 0; i++) @(posedge clk);
        #1;
        chk(nm, sbq.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && frame_valid && frame_ready) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_word", frame_data, 32'hxxxx_xxxx);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                chk("sb_addr", {24'h0, frame_addr}, {24'h0, e.addr});
                chk("sb_data", frame_data, e.data);
                chk("sb_last", {31'h0, frame_last}, {31'h0, e.last});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_data = '0; in_strobe = 1'b0; in_active = 1'b1; frame_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("rst_valid", {31'h0, frame_valid}, 0);
        chk("rst_addr",  {24'h0, frame_addr}, 0);
        chk("rst_data",  frame_data, 0);
        chk("rst_last",  {31'h0, frame_last}, 0);
        chk("rst_busy",  {31'h0, busy}, 0);
        chk("rst_done",  {31'h0, done}, 0);
        chk("rst_err",   {31'h0, error}, 0);
        chk("rst_wl",    {16'h0, words_loaded}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic frame, ready held high.
        vt.push_back('{SYNC,          1, 1, 0, 8'h00, 0, 0, 1, 16'd0, 0});
        vt.push_back('{32'h0000_0005, 1, 1, 0, 8'h00, 0, 0, 1, 16'd0, 0});
        vt.push_back('{32'h0000_0011, 1, 1, 1, 8'h05, 0, 0, 1, 16'd1, 0});
        vt.push_back('{32'h0000_0012, 1, 1, 1, 8'h05, 0, 0, 1, 16'd2, 0});
        vt.push_back('{32'h0000_0013, 1, 1, 1, 8'h05, 0, 0, 1, 16'd3, 0});
        vt.push_back('{32'h0000_0014, 1, 1, 1, 8'h05, 1, 0, 1, 16'd4, 0});
`ifdef JTAG_FRAME_LOADER_CHECKSUM_EN
        vt.push_back('{32'h0000_0001, 1, 1, 0, 8'h00, 0, 0, 1, 16'd4, 0});
`endif
        vt.push_back('{ENDW,          1, 1, 0, 8'h00, 0, 1, 0, 16'd4, 0});
        vt.push_back('{32'h0000_0000, 0, 1, 0, 8'h00, 0, 0, 0, 16'd4, 0});
        foreach (vt[i]) begin
            in_data     = vt[i].d;
            in_strobe   = vt[i].stb;
            frame_ready = vt[i].rdy;
            if (vt[i].fwd) sbq.push_back('{vt[i].fa, vt[i].d, vt[i].fl});
            @(posedge clk); #1;
            in_strobe = 1'b0;
            chk($sformatf("vec%0d_done", i), {31'h0, done},  {31'h0, vt[i].e_done});
            chk($sformatf("vec%0d_busy", i), {31'h0, busy},  {31'h0, vt[i].e_busy});
            chk($sformatf("vec%0d_wl", i),   {16'h0, words_loaded}, {16'h0, vt[i].e_wl});
            chk($sformatf("vec%0d_err", i),  {31'h0, error}, {31'h0, vt[i].e_err});
        end
        drain("basic_drain");

        // Backpressure: fill the FIFO, then two words of the next frame are dropped.
        frame_ready = 1'b0;
        stb(SYNC);
        stb_addr(8'h07);
        for (int k = 0; k < 4; k++) stb_data(32'h21 + k, 1'b1);
        send_chk();
        stb_addr(8'h08);
        stb_data(32'h25, 1'b0);
        stb_data(32'h26, 1'b0);
        chk("bp_err",   {31'h0, error}, 1);
        chk("bp_wl",    {16'h0, words_loaded}, 4);
        chk("bp_valid", {31'h0, frame_valid}, 1);
        chk("bp_head",  frame_data, 32'h21);
        frame_ready = 1'b1;
        drain("bp_drain");
        stb_data(32'h27, 1'b1);
        stb_data(32'h28, 1'b1);
        send_chk();
        stb(ENDW);
        chk("bp_done", {31'h0, done}, 1);
        drain("bp_drain2");
        chk("bp_wl_final",  {16'h0, words_loaded}, 6);
        chk("bp_err_stick", {31'h0, error}, 1);

        // Full FIFO with a same-cycle read: no drop.
        frame_ready = 1'b0;
        stb(SYNC);
        chk("rw_err_cleared", {31'h0, error}, 0);
        chk("rw_wl_cleared",  {16'h0, words_loaded}, 0);
        stb_addr(8'h09);
        for (int k = 0; k < 4; k++) stb_data(32'h31 + k, 1'b1);
        send_chk();
        stb_addr(8'h0A);
        frame_ready = 1'b1;
        stb_data(32'h35, 1'b1);
        chk("rw_err", {31'h0, error}, 0);
        chk("rw_wl",  {16'h0, words_loaded}, 5);
        for (int k = 0; k < 3; k++) stb_data(32'h36 + k, 1'b1);
        send_chk();
        stb(ENDW);
        drain("rw_drain");
        chk("rw_err_final", {31'h0, error}, 0);
        chk("rw_wl_final",  {16'h0, words_loaded}, 8);

        // Abort after two data words.
        frame_ready = 1'b0;
        stb(SYNC);
        stb_addr(8'h0B);
        stb_data(32'h41, 1'b1);
        stb_data(32'h42, 1'b1);
        in_active = 1'b0;
        @(posedge clk); #1;
        chk("ab_err",   {31'h0, error}, 1);
        chk("ab_busy",  {31'h0, busy}, 1);
        chk("ab_valid", {31'h0, frame_valid}, 1);
        in_active   = 1'b1;
        frame_ready = 1'b1;
        drain("ab_drain");
        chk("ab_idle_busy", {31'h0, busy}, 0);
        stb(SYNC);
        chk("ab_sync_idle_err", {31'h0, error}, 1);
        stb(ENDW);
        chk("ab_done", {31'h0, done}, 1);
        stb(SYNC);
        chk("ab_sync_done_err", {31'h0, error}, 0);
        chk("ab_sync_done_wl",  {16'h0, words_loaded}, 0);

        // Reset mid-frame with words held in the FIFO.
        frame_ready = 1'b0;
        stb_addr(8'h0C);
        stb_data(32'h51, 1'b0);
        stb_data(32'h52, 1'b0);
        chk("mr_pre_valid", {31'h0, frame_valid}, 1);
        chk("mr_pre_wl",    {16'h0, words_loaded}, 2);
        rst = 1'b1;
        #1;
        chk("mr_valid", {31'h0, frame_valid}, 0);
        chk("mr_addr",  {24'h0, frame_addr}, 0);
        chk("mr_data",  frame_data, 0);
        chk("mr_last",  {31'h0, frame_last}, 0);
        chk("mr_busy",  {31'h0, busy}, 0);
        chk("mr_wl",    {16'h0, words_loaded}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        stb(32'h0000_0005);
        chk("mr_idle_busy",  {31'h0, busy}, 0);
        chk("mr_idle_valid", {31'h0, frame_valid}, 0);

`ifdef JTAG_FRAME_LOADER_CHECKSUM_EN
        frame_ready = 1'b1;
        stb(SYNC);
        stb_addr(8'h01);
        for (int k = 1; k <= 4; k++) stb_data(32'h10 * k, 1'b1);
        stb(32'h41);
        chk("cs_good_err", {31'h0, error}, 0);
        stb_addr(8'h01);
        for (int k = 1; k <= 4; k++) stb_data(32'h10 * k, 1'b1);
        stb(32'h42);
        chk("cs_bad_err", {31'h0, error}, 1);
        stb(ENDW);
        drain("cs_drain");
`endif

        chk("sb_empty_final", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
